waveform_infer_ctrl: RTL and testbench
======================================

Name: waveform_infer_ctrl

Overview:
Sequencer for the hls4ml waveform core `myproject_0`, which uses `ap_ctrl_hs` with an `ap_vld` input and outputs.
- Accepts a serial stream of 18-bit ADC samples and packs `N_SAMPLES` of them into the 1800-bit `input_1` word.
- Launches the core, waits for `ap_done`, and latches the mean and sigma results.
- Presents the results on a valid/ready output, with timeout protection and a completed-frame counter.

Parameters:
- `N_SAMPLES`, 100, samples per inference frame.
- `SAMPLE_W`, 18, sample width (ap_fixed bits).
- `RESULT_W`, 24, width of each core output.
- `TIMEOUT_CYCLES`, 4096, maximum cycles from launch to `ap_done` before abort.
- `CNT_W`, 16, width of the frame counter.

Ports:
- `ap_clk`  in  1  single clock.
- `ap_rst`  in  1  synchronous reset, active-high.
- `s_sample_data`  in  `SAMPLE_W`  sample stream data.
- `s_sample_valid`  in  1  sample valid.
- `s_sample_ready`  out  1  sample ready.
- `core_ap_start`  out  1  to core `ap_start`.
- `core_ap_ready`  in  1  from core.
- `core_ap_done`  in  1  from core.
- `core_ap_idle`  in  1  from core; status only.
- `core_input_1`  out  `N_SAMPLES*SAMPLE_W`  packed frame to core.
- `core_input_1_ap_vld`  out  1  frame valid to core.
- `core_out_0`  in  `RESULT_W`  core mean.
- `core_out_0_ap_vld`  in  1  mean valid.
- `core_out_1`  in  `RESULT_W`  core sigma.
- `core_out_1_ap_vld`  in  1  sigma valid.
- `m_mean`  out  `RESULT_W`  latched mean.
- `m_sigma`  out  `RESULT_W`  latched sigma.
- `m_partial`  out  1  one or both results missing at `ap_done`.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result consumed.
- `busy`  out  1  state is not FILL.
- `timeout_err`  out  1  sticky; frame aborted by timeout.
- `err_clr`  in  1  clears `timeout_err`.
- `frame_count`  out  `CNT_W`  results delivered; wraps modulo 2^`CNT_W`.

Behaviour:
- **Clocking and reset:** all state updates on rising `ap_clk`. When `ap_rst`=1:
  - state goes to FILL and the sample index goes to 0;
  - all outputs are 0, including `s_sample_ready`, `core_input_1`, `m_*`, `timeout_err` and `frame_count`.
- **Reset mid-operation:** reset aborts any frame in flight. No result is emitted and `core_ap_start` drops the same cycle.
- **FILL:**
  - `s_sample_ready`=1.
  - Each accepted sample (valid&&ready) is written to `core_input_1[k*SAMPLE_W +: SAMPLE_W]`, where k is the arrival index starting at 0, then k increments.
  - On acceptance of sample `N_SAMPLES`-1, k resets to 0 and the next state is LAUNCH.
  - Sample 0 is the LSB slice.
- **LAUNCH:**
  - `s_sample_ready`=0; `core_ap_start`=1 and `core_input_1_ap_vld`=1.
  - Both are held until the cycle `core_ap_ready`=1, then deasserted from the next cycle. Next state is WAIT.
  - If `core_ap_ready` and `core_ap_done` are high in the same cycle, go directly to the done handling below.
  - `core_input_1` is frozen from LAUNCH until the return to FILL.
- **WAIT (also active in LAUNCH):**
  - `core_out_0` is latched into `m_mean` on `core_out_0_ap_vld`; `core_out_1` is latched into `m_sigma` on `core_out_1_ap_vld`.
  - A seen-flag is set per output. The vld pulses may arrive in any cycle up to and including the `ap_done` cycle.
- **Done handling:**
  - On `core_ap_done`=1, go to OUT and drive `m_valid`=1 from the next cycle.
  - `m_partial`=1 if either seen-flag is clear at done (counting vlds arriving in the done cycle). A missing field reads 0.
- **OUT:**
  - `m_mean`, `m_sigma` and `m_partial` are stable while `m_valid`=1.
  - On `m_valid`&&`m_ready`: `frame_count`++, the seen-flags clear, `m_valid` drops next cycle and the state returns to FILL.
  - Back-to-back frame latency: the first sample of the next frame is accepted the cycle after the handshake.
- **Timeout:**
  - A cycle counter resets on entry to LAUNCH and counts in LAUNCH and WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `ap_done`: set `timeout_err`, drop `core_ap_start`, discard the frame and return to FILL. `m_valid` is never asserted for that frame.
  - `ap_done` in the same cycle as expiry wins: the frame is reported normally.
- **`err_clr`:** clears `timeout_err` next cycle. If a new timeout occurs in the same cycle, set wins.
- **Ignored core signals:** `core_ap_done`, `core_out_0_ap_vld` and `core_out_1_ap_vld` are ignored in FILL and OUT.

Test Plan:
1. Reset 5 cycles, then stream 100 samples 18'h01AA0 with continuous valid -> `core_input_1` = 100 copies; `core_ap_start` and `core_input_1_ap_vld` rise the cycle after sample 99; `s_sample_ready`=0 from then on.
2. Core model: `ap_ready` 2 cycles after start, `out_0`=24'h000123 and `out_1`=24'h000045 with vld 20 cycles later, `ap_done` the same cycle -> `m_valid`=1, `m_mean`=000123, `m_sigma`=000045, `m_partial`=0; `m_ready` held low 5 cycles -> values stable; on handshake `frame_count`=1.
3. `out_0` vld at cycle 10, `out_1` vld missing, `ap_done` at 12 -> `m_mean` latched, `m_sigma`=0, `m_partial`=1.
4. Core never asserts `ap_done`, `TIMEOUT_CYCLES`=64 -> `timeout_err`=1 at launch+64, no `m_valid`, `s_sample_ready`=1 next cycle; `err_clr` pulse -> `timeout_err`=0.
5. `ap_rst` asserted at sample 50 and mid-WAIT -> all outputs 0; next frame packs sample 0 at the LSB correctly.
6. Gapped `s_sample_valid` (1 of 3 cycles) over 3 back-to-back frames with `m_ready` tied high -> `frame_count`=3 and ramp data 0..99 packed in order.

Source files
------------

// File: rtl/waveform_infer_ctrl_if.sv
// Bus bundle between the waveform sequencer and its surroundings: sample stream in,
// hls4ml core handshake (ap_ctrl_hs + ap_vld) and the result valid/ready channel.
interface waveform_infer_ctrl_if #(
    parameter int N_SAMPLES = 100,
    parameter int SAMPLE_W  = 18,
    parameter int RESULT_W  = 24
);
    logic [SAMPLE_W-1:0]           s_sample_data;
    logic                          s_sample_valid;
    logic                          s_sample_ready;

    logic                          core_ap_start;
    logic                          core_ap_ready;
    logic                          core_ap_done;
    logic                          core_ap_idle;
    logic [N_SAMPLES*SAMPLE_W-1:0] core_input_1;
    logic                          core_input_1_ap_vld;
    logic [RESULT_W-1:0]           core_out_0;
    logic                          core_out_0_ap_vld;
    logic [RESULT_W-1:0]           core_out_1;
    logic                          core_out_1_ap_vld;

    logic [RESULT_W-1:0]           m_mean;
    logic [RESULT_W-1:0]           m_sigma;
    logic                          m_partial;
    logic                          m_valid;
    logic                          m_ready;

    // Sequencer side: it sequences the core and owns the result channel.
    modport master (
        input  s_sample_data, s_sample_valid,
        output s_sample_ready,
        output core_ap_start, core_input_1, core_input_1_ap_vld,
        input  core_ap_ready, core_ap_done, core_ap_idle,
        input  core_out_0, core_out_0_ap_vld, core_out_1, core_out_1_ap_vld,
        output m_mean, m_sigma, m_partial, m_valid,
        input  m_ready
    );

    modport slave (
        output s_sample_data, s_sample_valid,
        input  s_sample_ready,
        input  core_ap_start, core_input_1, core_input_1_ap_vld,
        output core_ap_ready, core_ap_done, core_ap_idle,
        output core_out_0, core_out_0_ap_vld, core_out_1, core_out_1_ap_vld,
        input  m_mean, m_sigma, m_partial, m_valid,
        output m_ready
    );
endinterface

// File: rtl/waveform_infer_ctrl.sv
// Frame sequencer for the hls4ml waveform core: packs N_SAMPLES ADC samples, launches
// the core, collects mean/sigma with a launch timeout and hands results downstream.
module waveform_infer_ctrl #(
    parameter int N_SAMPLES      = 100,
    parameter int SAMPLE_W       = 18,
    parameter int RESULT_W       = 24,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    waveform_infer_ctrl_if.master  bus,
    output logic                   busy,
    output logic                   timeout_err,
    input  logic                   err_clr,
    output logic [CNT_W-1:0]       frame_count
);
    localparam int IDX_W = $clog2(N_SAMPLES);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    state_t                        state_q;
    logic [IDX_W-1:0]              idx_q;
    logic [N_SAMPLES*SAMPLE_W-1:0] frame_q;
    logic [TMR_W-1:0]              timer_q;
    logic                          ready_q;
    logic                          start_q;
    logic                          busy_q;
    logic [RESULT_W-1:0]           mean_q;
    logic [RESULT_W-1:0]           sigma_q;
    logic                          seen0_q;
    logic                          seen1_q;
    logic                          partial_q;
    logic                          valid_q;
    logic                          tmo_err_q;
    logic [CNT_W-1:0]              frame_cnt_q;

    logic accept_s;
    logic active_s;
    logic done_s;
    logic expire_s;
    logic unused_idle_s;

    assign unused_idle_s = bus.core_ap_idle;

    // Per-cycle events: sample acceptance, core completion and launch timeout expiry.
    always_comb begin
        accept_s = 1'b0;
        active_s = 1'b0;
        done_s   = 1'b0;
        expire_s = 1'b0;
        if (state_q == ST_FILL) begin
            accept_s = ready_q & bus.s_sample_valid;
        end else begin
            active_s = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
        end
        if (active_s) begin
            done_s   = bus.core_ap_done;
            expire_s = ~bus.core_ap_done && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
        end else begin
            done_s   = 1'b0;
            expire_s = 1'b0;
        end
    end

    // Sequencer FSM with all outputs registered; done beats a coincident timeout.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= ST_FILL;
            idx_q       <= '0;
            frame_q     <= '0;
            timer_q     <= '0;
            ready_q     <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            mean_q      <= '0;
            sigma_q     <= '0;
            seen0_q     <= 1'b0;
            seen1_q     <= 1'b0;
            partial_q   <= 1'b0;
            valid_q     <= 1'b0;
            tmo_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (expire_s) begin
                tmo_err_q <= 1'b1;
            end else if (err_clr) begin
                tmo_err_q <= 1'b0;
            end

            case (state_q)
                ST_FILL: begin
                    ready_q <= 1'b1;
                    if (accept_s) begin
                        frame_q[idx_q*SAMPLE_W +: SAMPLE_W] <= bus.s_sample_data;
                        if (idx_q == IDX_W'(N_SAMPLES - 1)) begin
                            idx_q   <= '0;
                            state_q <= ST_LAUNCH;
                            ready_q <= 1'b0;
                            start_q <= 1'b1;
                            busy_q  <= 1'b1;
                            timer_q <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_LAUNCH, ST_WAIT: begin
                    timer_q <= timer_q + TMR_W'(1);
                    if (bus.core_out_0_ap_vld) begin
                        mean_q  <= bus.core_out_0;
                        seen0_q <= 1'b1;
                    end
                    if (bus.core_out_1_ap_vld) begin
                        sigma_q <= bus.core_out_1;
                        seen1_q <= 1'b1;
                    end
                    if (done_s) begin
                        state_q   <= ST_OUT;
                        start_q   <= 1'b0;
                        valid_q   <= 1'b1;
                        partial_q <= ~(seen0_q | bus.core_out_0_ap_vld) |
                                     ~(seen1_q | bus.core_out_1_ap_vld);
                    end else if (expire_s) begin
                        // Abandon the frame: anything latched so far must not leak into the next one.
                        state_q <= ST_FILL;
                        start_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        mean_q  <= '0;
                        sigma_q <= '0;
                        seen0_q <= 1'b0;
                        seen1_q <= 1'b0;
                    end else if ((state_q == ST_LAUNCH) && bus.core_ap_ready) begin
                        start_q <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_OUT: begin
                    if (bus.m_ready) begin
                        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        state_q     <= ST_FILL;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b0;
                        valid_q     <= 1'b0;
                        partial_q   <= 1'b0;
                        mean_q      <= '0;
                        sigma_q     <= '0;
                        seen0_q     <= 1'b0;
                        seen1_q     <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    // Start/vld are masked by reset so an in-flight launch is withdrawn immediately.
    assign bus.core_ap_start       = start_q & ~ap_rst;
    assign bus.core_input_1_ap_vld = start_q & ~ap_rst;
    assign bus.core_input_1        = frame_q;
    assign bus.s_sample_ready      = ready_q;
    assign bus.m_mean              = mean_q;
    assign bus.m_sigma             = sigma_q;
    assign bus.m_partial           = partial_q;
    assign bus.m_valid             = valid_q;
    assign busy                    = busy_q;
    assign timeout_err             = tmo_err_q;
    assign frame_count             = frame_cnt_q;
endmodule

// File: tb/tb_waveform_infer_ctrl.sv
// Directed bench for waveform_infer_ctrl: hand-computed frames, core responses,
// timeout, reset abort and back-to-back gapped frames.
module tb_waveform_infer_ctrl;
    localparam int N  = 100;
    localparam int SW = 18;
    localparam int RW = 24;
    localparam int TO = 64;
    localparam int CW = 16;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic          err_clr = 1'b0;
    logic          busy;
    logic          timeout_err;
    logic [CW-1:0] frame_count;
    logic [N*SW-1:0] exp_frame;
    int n_cmp = 0;
    int n_err = 0;

    waveform_infer_ctrl_if #(.N_SAMPLES(N), .SAMPLE_W(SW), .RESULT_W(RW)) bus ();

    waveform_infer_ctrl #(
        .N_SAMPLES(N), .SAMPLE_W(SW), .RESULT_W(RW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus), .busy(busy),
        .timeout_err(timeout_err), .err_clr(err_clr), .frame_count(frame_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send_sample(input logic [SW-1:0] d, input int gap);
        logic r;
        r = 1'b0;
        bus.s_sample_valid = 1'b0;
        repeat (gap) tick();
        bus.s_sample_data  = d;
        bus.s_sample_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            r = bus.s_sample_ready;
            tick();
            if (r) break;
        end
        if (!r) check_val("accept_bound", {63'd0, r}, 64'd1);
    endtask

    // Sends samples base + step*k for k = 0..cnt-1 and mirrors them into exp_frame.
    task automatic fill_frame(input logic [SW-1:0] base, input logic [SW-1:0] step,
                              input int gap, input int cnt);
        logic [SW-1:0] d;
        exp_frame = '0;
        for (int k = 0; k < cnt; k++) begin
            d = base + step * SW'(k);
            exp_frame[k*SW +: SW] = d;
            send_sample(d, gap);
        end
        bus.s_sample_valid = 1'b0;
    endtask

    // Core model; cycle 0 is the first cycle core_ap_start is visible. -1 disables an event.
    task automatic run_core(input int rdy, input int v0, input int v1, input int dn, input int ncyc,
                            input logic [RW-1:0] o0, input logic [RW-1:0] o1);
        for (int c = 0; c < ncyc; c++) begin
            if (c == rdy)     check_val("start_held", {63'd0, bus.core_ap_start}, 64'd1);
            if (c == rdy + 1) check_val("start_drop", {63'd0, bus.core_ap_start}, 64'd0);
            bus.core_ap_ready     = (c == rdy);
            bus.core_out_0_ap_vld = (c == v0);
            bus.core_out_0        = (c == v0) ? o0 : 24'hBADBAD;
            bus.core_out_1_ap_vld = (c == v1);
            bus.core_out_1        = (c == v1) ? o1 : 24'hBADBAD;
            bus.core_ap_done      = (c == dn);
            tick();
        end
        bus.core_ap_ready     = 1'b0;
        bus.core_out_0_ap_vld = 1'b0;
        bus.core_out_1_ap_vld = 1'b0;
        bus.core_ap_done      = 1'b0;
        bus.core_out_0        = 24'd0;
        bus.core_out_1        = 24'd0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_rdy"},   {63'd0, bus.s_sample_ready}, 64'd0);
        check_val({tag, "_start"}, {63'd0, bus.core_ap_start}, 64'd0);
        check_val({tag, "_frame0"}, {63'd0, (bus.core_input_1 == '0)}, 64'd1);
        check_val({tag, "_mvalid"}, {63'd0, bus.m_valid}, 64'd0);
        check_val({tag, "_mean"},  {40'd0, bus.m_mean}, 64'd0);
        check_val({tag, "_busy"},  {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic mv_seen;
        bus.s_sample_data = '0;  bus.s_sample_valid = 1'b0;
        bus.core_ap_ready = 1'b0; bus.core_ap_done = 1'b0; bus.core_ap_idle = 1'b1;
        bus.core_out_0 = '0; bus.core_out_0_ap_vld = 1'b0;
        bus.core_out_1 = '0; bus.core_out_1_ap_vld = 1'b0;
        bus.m_ready = 1'b0;

        // 1: reset, constant frame, launch
        repeat (5) tick();
        check_idle_outputs("rst");
        check_val("rst_tmo", {63'd0, timeout_err}, 64'd0);
        check_val("rst_cnt", {48'd0, frame_count}, 64'd0);
        check_val("rst_vld", {63'd0, bus.core_input_1_ap_vld}, 64'd0);
        ap_rst = 1'b0;
        fill_frame(18'h01AA0, 18'd0, 0, N);
        check_val("t1_start", {63'd0, bus.core_ap_start}, 64'd1);
        check_val("t1_invld", {63'd0, bus.core_input_1_ap_vld}, 64'd1);
        check_val("t1_rdy",   {63'd0, bus.s_sample_ready}, 64'd0);
        check_val("t1_busy",  {63'd0, busy}, 64'd1);
        check_val("t1_frame", {63'd0, (bus.core_input_1 == exp_frame)}, 64'd1);

        // 2: full result, held while m_ready low
        run_core(2, 20, 20, 20, 21, 24'h000123, 24'h000045);
        check_val("t2_rdy_wait", {63'd0, bus.s_sample_ready}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            check_val("t2_mvalid", {63'd0, bus.m_valid}, 64'd1);
            check_val("t2_mean",   {40'd0, bus.m_mean}, 64'h123);
            check_val("t2_sigma",  {40'd0, bus.m_sigma}, 64'h45);
            check_val("t2_partial", {63'd0, bus.m_partial}, 64'd0);
            tick();
        end
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        check_val("t2_mvalid_drop", {63'd0, bus.m_valid}, 64'd0);
        check_val("t2_cnt", {48'd0, frame_count}, 64'd1);
        check_val("t2_rdy", {63'd0, bus.s_sample_ready}, 64'd1);

        // 3: sigma missing at done
        fill_frame(18'h00100, 18'd3, 0, N);
        check_val("t3_frame", {63'd0, (bus.core_input_1 == exp_frame)}, 64'd1);
        run_core(2, 10, -1, 12, 13, 24'h0A0B0C, 24'h111111);
        check_val("t3_mvalid",  {63'd0, bus.m_valid}, 64'd1);
        check_val("t3_mean",    {40'd0, bus.m_mean}, 64'h0A0B0C);
        check_val("t3_sigma",   {40'd0, bus.m_sigma}, 64'd0);
        check_val("t3_partial", {63'd0, bus.m_partial}, 64'd1);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        check_val("t3_cnt", {48'd0, frame_count}, 64'd2);

        // 4: no ap_done -> timeout at launch+TO
        fill_frame(18'h00055, 18'd0, 0, N);
        mv_seen = 1'b0;
        for (int c = 0; c < TO; c++) begin
            bus.core_ap_ready = (c == 2);
            if (c == TO - 1) begin
                check_val("t4_tmo_early", {63'd0, timeout_err}, 64'd0);
                check_val("t4_busy_early", {63'd0, busy}, 64'd1);
            end
            mv_seen = mv_seen | bus.m_valid;
            tick();
        end
        bus.core_ap_ready = 1'b0;
        mv_seen = mv_seen | bus.m_valid;
        check_val("t4_tmo",    {63'd0, timeout_err}, 64'd1);
        check_val("t4_novalid", {63'd0, mv_seen}, 64'd0);
        check_val("t4_rdy",    {63'd0, bus.s_sample_ready}, 64'd1);
        check_val("t4_start",  {63'd0, bus.core_ap_start}, 64'd0);
        check_val("t4_busy",   {63'd0, busy}, 64'd0);
        tick();
        check_val("t4_sticky", {63'd0, timeout_err}, 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_val("t4_clr", {63'd0, timeout_err}, 64'd0);
        check_val("t4_cnt", {48'd0, frame_count}, 64'd2);

        // 5a: reset at sample 50
        fill_frame(18'h3FFFF, 18'd0, 0, 50);
        bus.s_sample_valid = 1'b1;
        ap_rst = 1'b1;
        tick();
        check_idle_outputs("t5a");
        check_val("t5a_cnt", {48'd0, frame_count}, 64'd0);
        ap_rst = 1'b0;
        bus.s_sample_valid = 1'b0;

        // 5b: fresh frame packs sample 0 at the LSB; reset during launch drops start at once
        fill_frame(18'h20000, 18'd1, 0, N);
        check_val("t5b_lsb",   {46'd0, bus.core_input_1[SW-1:0]}, 64'h20000);
        check_val("t5b_s1",    {46'd0, bus.core_input_1[2*SW-1:SW]}, 64'h20001);
        check_val("t5b_frame", {63'd0, (bus.core_input_1 == exp_frame)}, 64'd1);
        ap_rst = 1'b1;
        #1;
        check_val("t5b_start_rst", {63'd0, bus.core_ap_start}, 64'd0);
        tick();
        ap_rst = 1'b0;

        // 5c: reset mid-WAIT after mean was latched
        fill_frame(18'h00777, 18'd0, 0, N);
        run_core(2, 3, -1, -1, 6, 24'h00ABCD, 24'h0);
        ap_rst = 1'b1;
        tick();
        check_idle_outputs("t5c");
        ap_rst = 1'b0;

        // 6: three gapped back-to-back frames, m_ready tied high
        bus.m_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            fill_frame(18'd0, 18'd1, 2, N);
            check_val("t6_frame", {63'd0, (bus.core_input_1 == exp_frame)}, 64'd1);
            run_core(2, 5, 6, 8, 9, 24'(f + 1), 24'(f + 16));
            check_val("t6_mvalid", {63'd0, bus.m_valid}, 64'd1);
            check_val("t6_mean",   {40'd0, bus.m_mean}, 64'(f + 1));
            check_val("t6_sigma",  {40'd0, bus.m_sigma}, 64'(f + 16));
            tick();
            check_val("t6_handshake", {63'd0, bus.m_valid}, 64'd0);
        end
        check_val("t6_cnt", {48'd0, frame_count}, 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
